// File: rtl/io_pkg.sv
// Shared constants for the core-to-UART I/O buffer.
package io_pkg;

    // Default log2 depth of each FIFO (16 entries).
    localparam int IO_DEPTH_LOG2_DEFAULT = 4;

    // Width of a transferred byte.
    localparam int IO_BYTE_W = 8;

    // Core data word width.
    localparam int IO_WORD_W = 32;

    // Zero-extend a byte to a core word.
    function automatic logic [IO_WORD_W-1:0] io_zext(input logic [IO_BYTE_W-1:0] b);
        return {{(IO_WORD_W-IO_BYTE_W){1'b0}}, b};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with register-array storage and a combinational head read.
// Flags derive from the registered count, so a full FIFO refuses a push even
// when a pop happens in the same cycle. The head reads as zero while empty.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = DEPTH[DEPTH_LOG2:0];

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage write; data array needs no reset since empty masks the head.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; reset empties the FIFO at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_buffer.sv
// Byte buffer between the core's I/O port and the UART byte engine.
// TX FIFO collects output bytes for the UART, RX FIFO holds received bytes
// for the core; stalls tell the core to hold its I/O instruction.
module io_buffer
    import io_pkg::*;
#(
    parameter int DEPTH_LOG2 = IO_DEPTH_LOG2_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  out_issued,
    input  logic [31:0]           out_data,
    output logic                  out_stall,
    input  logic                  in_issued,
    output logic [31:0]           in_data,
    output logic                  in_stall,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_overflow,
    output logic [DEPTH_LOG2:0]   tx_count,
    output logic [DEPTH_LOG2:0]   rx_count
);

    logic                 tx_full;
    logic                 tx_empty;
    logic                 rx_full;
    logic                 rx_empty;
    logic [IO_BYTE_W-1:0] rx_head;

    // Only the low byte of an output word is transmitted.
    logic unused_out_hi;
    assign unused_out_hi = ^out_data[31:8];

    assign out_stall = out_issued & tx_full;
    assign tx_valid  = ~tx_empty;
    assign in_stall  = in_issued & rx_empty;
    assign in_data   = io_zext(rx_head);

    sync_fifo #(
        .WIDTH      (IO_BYTE_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (out_issued & ~tx_full),
        .pop   (tx_valid & tx_ready),
        .din   (out_data[7:0]),
        .dout  (tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(
        .WIDTH      (IO_BYTE_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_valid & ~rx_full),
        .pop   (in_issued & ~rx_empty),
        .din   (rx_data),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    // Sticky overflow: a byte arriving while RX is full is lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_overflow <= 1'b0;
        end else if (rx_valid & rx_full) begin
            rx_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_io_buffer.sv
// Directed self-checking bench for io_buffer.
module tb_io_buffer;

    logic        clk;
    logic        rst;
    logic        out_issued;
    logic [31:0] out_data;
    logic        out_stall;
    logic        in_issued;
    logic [31:0] in_data;
    logic        in_stall;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_overflow;
    logic [4:0]  tx_count;
    logic [4:0]  rx_count;

    int n_checks = 0;
    int n_pass   = 0;

    io_buffer #(.DEPTH_LOG2(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .out_issued  (out_issued),
        .out_data    (out_data),
        .out_stall   (out_stall),
        .in_issued   (in_issued),
        .in_data     (in_data),
        .in_stall    (in_stall),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_overflow (rx_overflow),
        .tx_count    (tx_count),
        .rx_count    (rx_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst        = 1'b0;
        out_issued = 1'b0;
        out_data   = '0;
        in_issued  = 1'b0;
        tx_ready   = 1'b0;
        rx_data    = '0;
        rx_valid   = 1'b0;

        // Reset and idle
        step();
        step();
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_in_data", in_data, 32'd0);
        chk("rst_tx_count", 32'(tx_count), 32'd0);
        chk("rst_rx_count", 32'(rx_count), 32'd0);
        chk("rst_overflow", 32'(rx_overflow), 32'd0);
        chk("rst_in_stall", 32'(in_stall), 32'd0);
        chk("rst_out_stall", 32'(out_stall), 32'd0);
        rst = 1'b1;
        step();
        chk("idle_tx_valid", 32'(tx_valid), 32'd0);
        chk("idle_in_stall", 32'(in_stall), 32'd0);
        in_issued = 1'b1;
        settle();
        chk("idle_in_stall_held", 32'(in_stall), 32'd1);
        chk("idle_in_data", in_data, 32'd0);
        in_issued = 1'b0;
        step();

        // Single output byte with UART ready
        out_data   = 32'h1234_5641;
        out_issued = 1'b1;
        tx_ready   = 1'b1;
        settle();
        chk("out_no_stall", 32'(out_stall), 32'd0);
        chk("out_not_yet_valid", 32'(tx_valid), 32'd0);
        step();
        out_issued = 1'b0;
        settle();
        chk("out_tx_valid", 32'(tx_valid), 32'd1);
        chk("out_tx_data", 32'(tx_data), 32'h41);
        chk("out_tx_count1", 32'(tx_count), 32'd1);
        step();
        chk("out_tx_count0", 32'(tx_count), 32'd0);
        chk("out_tx_valid0", 32'(tx_valid), 32'd0);

        // Fill TX, stall, single pop releases stall
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            out_data   = 32'(i);
            out_issued = 1'b1;
            step();
        end
        chk("txfull_count", 32'(tx_count), 32'd16);
        out_data = 32'd16;
        settle();
        chk("txfull_stall", 32'(out_stall), 32'd1);
        step();
        chk("txfull_count_held", 32'(tx_count), 32'd16);
        chk("txfull_head", 32'(tx_data), 32'd0);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        settle();
        chk("txfull_push_refused", 32'(tx_count), 32'd15);
        chk("txfull_stall_clear", 32'(out_stall), 32'd0);
        step();
        out_issued = 1'b0;
        chk("txfull_refill", 32'(tx_count), 32'd16);
        tx_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            settle();
            chk($sformatf("tx_order_%0d", i), 32'(tx_data), 32'(i));
            step();
        end
        tx_ready = 1'b0;
        chk("tx_drained", 32'(tx_count), 32'd0);

        // RX wait then single byte arrival
        in_issued = 1'b1;
        settle();
        chk("rxwait_stall", 32'(in_stall), 32'd1);
        step();
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        settle();
        chk("rxwait_stall_cycleN", 32'(in_stall), 32'd1);
        step();
        rx_valid = 1'b0;
        settle();
        chk("rxwait_stall_clear", 32'(in_stall), 32'd0);
        chk("rxwait_in_data", in_data, 32'h0000_00A5);
        chk("rxwait_count1", 32'(rx_count), 32'd1);
        step();
        in_issued = 1'b0;
        chk("rxwait_count0", 32'(rx_count), 32'd0);
        chk("rxwait_in_data0", in_data, 32'd0);

        // RX overflow
        for (int i = 0; i < 17; i++) begin
            rx_data  = 8'(8'h30 + i);
            rx_valid = 1'b1;
            if (i == 16) chk("ovf_not_yet", 32'(rx_overflow), 32'd0);
            step();
        end
        rx_valid = 1'b0;
        chk("ovf_count", 32'(rx_count), 32'd16);
        chk("ovf_flag", 32'(rx_overflow), 32'd1);
        in_issued = 1'b1;
        for (int i = 0; i < 16; i++) begin
            settle();
            chk($sformatf("rx_order_%0d", i), in_data, 32'(8'h30 + i));
            step();
        end
        in_issued = 1'b0;
        chk("ovf_drained", 32'(rx_count), 32'd0);
        chk("ovf_sticky", 32'(rx_overflow), 32'd1);

        // Both FIFOs at 8 with simultaneous push and pop
        for (int i = 0; i < 8; i++) begin
            out_data   = 32'(8'h50 + i);
            out_issued = 1'b1;
            rx_data    = 8'(8'h60 + i);
            rx_valid   = 1'b1;
            step();
        end
        chk("sim_tx8", 32'(tx_count), 32'd8);
        chk("sim_rx8", 32'(rx_count), 32'd8);
        tx_ready  = 1'b1;
        in_issued = 1'b1;
        for (int i = 8; i < 12; i++) begin
            out_data = 32'(8'h50 + i);
            rx_data  = 8'(8'h60 + i);
            settle();
            chk($sformatf("sim_tx_head_%0d", i), 32'(tx_data), 32'(8'h50 + i - 8));
            chk($sformatf("sim_rx_head_%0d", i), in_data, 32'(8'h60 + i - 8));
            step();
            chk($sformatf("sim_tx_cnt_%0d", i), 32'(tx_count), 32'd8);
            chk($sformatf("sim_rx_cnt_%0d", i), 32'(rx_count), 32'd8);
        end
        out_issued = 1'b0;
        rx_valid   = 1'b0;
        tx_ready   = 1'b0;
        in_issued  = 1'b0;
        settle();
        chk("sim_tx_next", 32'(tx_data), 32'h54);
        chk("sim_rx_next", in_data, 32'h64);

        // Reset mid-stream empties everything without a clock edge
        rst = 1'b0;
        settle();
        chk("midrst_tx_count", 32'(tx_count), 32'd0);
        chk("midrst_rx_count", 32'(rx_count), 32'd0);
        chk("midrst_tx_valid", 32'(tx_valid), 32'd0);
        chk("midrst_tx_data", 32'(tx_data), 32'd0);
        chk("midrst_in_data", in_data, 32'd0);
        chk("midrst_overflow", 32'(rx_overflow), 32'd0);
        step();
        rst = 1'b1;
        step();
        chk("post_rst_tx_count", 32'(tx_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/io_buffer.md
# io_buffer

- Sits between the RISC-V pipeline core's I/O port and the UART byte engine.
- Transmit direction: buffers bytes issued by the core's output instruction in a TX FIFO and drains them to the UART.
- Receive direction: buffers bytes arriving from the UART in an RX FIFO and serves them to the core's input instruction.
- Generates the core's `out_stall` and `in_stall` hazard signals.

## Interface
Parameters:
- `DEPTH_LOG2`, default 4 — log2 of each FIFO depth (16 entries).

Ports:
- `clk`  in  1  — single clock; all state on rising edge.
- `rst`  in  1  — reset, asynchronous assert, active-low (0 = reset).
- `out_issued`  in  1  — core output instruction present this cycle (level, held while stalled).
- `out_data`  in  32  — core output word; only `[7:0]` is transmitted.
- `out_stall`  out  1  — core must hold its output instruction.
- `in_issued`  in  1  — core input instruction present this cycle (level, held while stalled).
- `in_data`  out  32  — received byte, zero-extended; valid when `in_issued & !in_stall`.
- `in_stall`  out  1  — core must hold its input instruction.
- `tx_data`  out  8  — byte to UART transmitter.
- `tx_valid`  out  1  — `tx_data` valid.
- `tx_ready`  in  1  — UART accepts the byte when `tx_valid & tx_ready`.
- `rx_data`  in  8  — byte from UART receiver.
- `rx_valid`  in  1  — one-cycle strobe; no back-pressure possible.
- `rx_overflow`  out  1  — sticky; set when a byte is dropped.
- `tx_count`, `rx_count`  out  `DEPTH_LOG2+1`  — current occupancy of each FIFO.

## Operation
TX path:
- Push: `out_issued & !tx_full` pushes `out_data[7:0]`.
- `out_stall = out_issued & tx_full`; purely combinational.
- Pop: `tx_valid = !tx_empty`, `tx_data = head`; the handshake `tx_valid & tx_ready` pops the head.

RX path:
- Push: `rx_valid & !rx_full` pushes `rx_data`.
- Overflow: `rx_valid & rx_full` drops the byte and sets `rx_overflow`, which stays set until reset.
- `in_stall = in_issued & rx_empty`.
- Pop: `in_issued & !rx_empty` pops the head.
- `in_data = {24'b0, head}`, combinational from the storage array; `0` when the FIFO is empty.

FIFO rules (both FIFOs):
- Full/empty flags derive from the registered count.
- Read and write pointers are `DEPTH_LOG2` bits wide and wrap modulo depth; count is `DEPTH_LOG2+1` bits wide.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Full with a pop in the same cycle: the push is still refused, because full is taken from the registered count.
- Empty: pop is impossible by construction; no fall-through.
- The core clears `out_issued` / `in_issued` after a non-stalled cycle. The block does not deduplicate: a level held for 2 unstalled cycles means 2 operations.

## Timing
- Reset values: both FIFOs empty, all pointers and counts 0, `tx_valid=0`, `tx_data=0`, `in_data=0`, `rx_overflow=0`. `out_stall`/`in_stall` follow their combinational equations (0 when the issue input is 0).
- A reset assertion mid-operation empties both FIFOs immediately; bytes in flight are lost.
- Core → UART latency: a byte pushed at edge N has `tx_valid=1` in cycle N+1 (one cycle from push to head).
- UART → core latency: a byte pushed at edge N satisfies `in_issued` in cycle N+1, not in cycle N.
- Stall release:
  - `out_stall` drops in the cycle after any TX pop that makes the FIFO non-full.
  - `in_stall` drops in the cycle after the first RX push.
- Maximum throughput: 1 push and 1 pop per cycle per FIFO.

## Structure
- Package `io_pkg`: `IO_DEPTH_LOG2_DEFAULT`, byte width constant `IO_BYTE_W = 8`.
- Sub-module `sync_fifo`:
  - parameters: `WIDTH`, `DEPTH_LOG2`;
  - ports: push/pop/din/dout/full/empty/count;
  - register-array storage with combinational head read;
  - instantiated twice (TX, RX).
- `io_buffer` itself contains only the handshake glue and the overflow flag.

## Test plan
- Reset then idle → `tx_valid=0`, `in_stall=0`, all counts 0, `rx_overflow=0`. Hold `in_issued=1` → `in_stall=1`, `in_data=0`.
- Out path: issue `out_data=0x12345641` with `tx_ready=1` → `tx_data=0x41`, `tx_valid=1` one cycle later. `tx_count` reaches 0 two cycles after issue.
- TX full: `tx_ready=0`, 16 issues → `tx_count=16`. The 17th `out_issued` → `out_stall=1`. One pop (`tx_ready=1` for 1 cycle) → stall clears the next cycle; byte order preserved 0..15.
- RX wait: `in_issued=1` held with the FIFO empty → `in_stall=1`. `rx_valid` strobe with `0xA5` at edge N → cycle N+1 `in_stall=0`, `in_data=0x000000A5`, `rx_count` returns to 0.
- RX overflow: 17 `rx_valid` strobes with no reads → `rx_count=16`, `rx_overflow=1`. Reading 16 bytes returns the first 16 in order; the flag remains 1.
- Simultaneous events: both FIFOs at count 8 with push and pop in the same cycle → counts stay 8, data order intact. Assert `rst=0` mid-stream → everything empty within the same cycle.
